// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

    localparam int REG_INDEX_WIDTH = 5;
    localparam int REG_COUNT       = 32;
    localparam int DATA_WIDTH      = 32;

    typedef struct packed {
        logic [REG_INDEX_WIDTH-1:0] index;
        logic [DATA_WIDTH-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer for long-latency results waiting for the register-file write port.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t      mem_q [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           do_push, do_pop;

    always_comb begin
        full     = (count_q == (PW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is don't-care while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port.
// Optional WB_BYPASS_EN adds operand-forwarding taps off the registered write stage.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH      = wb_pkg::DATA_WIDTH,
    parameter int LATE_FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               aluWriteValid,
    input  logic [4:0]                         aluWriteIndex,
    input  logic [DATA_WIDTH-1:0]              aluWriteData,
    input  logic                               lateIssueValid,
    input  logic [4:0]                         lateIssueIndex,
    input  logic                               lateResultValid,
    output logic                               lateResultReady,
    input  logic [4:0]                         lateResultIndex,
    input  logic [DATA_WIDTH-1:0]              lateResultData,
`ifdef WB_BYPASS_EN
    input  logic [4:0]                         source1RegisterIndex,
    input  logic [4:0]                         source2RegisterIndex,
    output logic                               bypass1Valid,
    output logic [DATA_WIDTH-1:0]              bypass1Data,
    output logic                               bypass2Valid,
    output logic [DATA_WIDTH-1:0]              bypass2Data,
`endif
    output logic [4:0]                         writeRegisterIndex,
    output logic [DATA_WIDTH-1:0]              writeRegisterData,
    output logic                               shouldWrite,
    output logic [31:0]                        pendingMask,
    output logic [$clog2(LATE_FIFO_DEPTH):0]   fifoCount
);

    wb_entry_t        fifo_head, late_entry;
    logic             fifo_full, fifo_empty;
    logic             late_accept, sel_alu, sel_fifo, sel_bypass, sel_any;
    logic             push, pop;
    logic [4:0]       sel_index;
    logic [DATA_WIDTH-1:0] sel_data;

    logic             should_write_q, should_write_d;
    logic [4:0]       write_index_q, write_index_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [31:0]      pending_q, pending_d;

    // Ready comes only from registered occupancy, so a full FIFO refuses even when popping.
    assign lateResultReady = !fifo_full;
    assign late_entry      = '{index: lateResultIndex, data: lateResultData};

    always_comb begin
        late_accept = lateResultValid && lateResultReady;
        sel_alu     = aluWriteValid;
        sel_fifo    = !aluWriteValid && !fifo_empty;
        sel_bypass  = !aluWriteValid && fifo_empty && late_accept;
        sel_any     = sel_alu || sel_fifo || sel_bypass;
        pop         = sel_fifo;
        push        = late_accept && !sel_bypass;

        sel_index = lateResultIndex;
        sel_data  = lateResultData;
        if (sel_alu) begin
            sel_index = aluWriteIndex;
            sel_data  = aluWriteData;
        end else if (sel_fifo) begin
            sel_index = fifo_head.index;
            sel_data  = fifo_head.data;
        end

        should_write_d = sel_any && (sel_index != 5'd0);
        write_index_d  = sel_any ? sel_index : write_index_q;
        write_data_d   = sel_any ? sel_data  : write_data_q;

        // Clear before set so a newly issued op to the same register stays outstanding.
        pending_d = pending_q;
        if (sel_fifo || sel_bypass) begin
            pending_d[sel_index] = 1'b0;
        end
        if (lateIssueValid) begin
            pending_d[lateIssueIndex] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            should_write_q <= 1'b0;
            write_index_q  <= '0;
            write_data_q   <= '0;
            pending_q      <= '0;
        end else begin
            should_write_q <= should_write_d;
            write_index_q  <= write_index_d;
            write_data_q   <= write_data_d;
            pending_q      <= pending_d;
        end
    end

    wb_result_fifo #(
        .DEPTH (LATE_FIFO_DEPTH)
    ) u_late_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (late_entry),
        .pop        (pop),
        .head_entry (fifo_head),
        .count      (fifoCount),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign shouldWrite        = should_write_q;
    assign writeRegisterIndex = write_index_q;
    assign writeRegisterData  = write_data_q;
    assign pendingMask        = pending_q;

`ifdef WB_BYPASS_EN
    always_comb begin
        bypass1Valid = should_write_q && (write_index_q == source1RegisterIndex)
                       && (write_index_q != 5'd0);
        bypass2Valid = should_write_q && (write_index_q == source2RegisterIndex)
                       && (write_index_q != 5'd0);
        bypass1Data  = write_data_q;
        bypass2Data  = write_data_q;
    end
`endif

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-side counterpart of the register file: merges single-cycle ALU results and long-latency results (loads, multi-cycle units) onto the file's single write port (writeRegisterIndex / writeRegisterData / shouldWrite).
- Buffers long-latency results in a small FIFO when the ALU has the port.
- Tracks destinations of in-flight long-latency ops in a pending scoreboard, which the hazard unit uses to stall.

Parameters:
- DATA_WIDTH, 32, register data width.
- LATE_FIFO_DEPTH, 2, late-result buffer entries (power of two, >=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- aluWriteValid  input  1  ALU result present this cycle; never stalled.
- aluWriteIndex  input  5  ALU destination register.
- aluWriteData  input  DATA_WIDTH  ALU result.
- lateIssueValid  input  1  long-latency op issued this cycle.
- lateIssueIndex  input  5  its destination register.
- lateResultValid  input  1  long-latency result offered.
- lateResultReady  output  1  result accepted when valid&&ready.
- lateResultIndex  input  5  result destination.
- lateResultData  input  DATA_WIDTH  result value.
- writeRegisterIndex  output  5  to register file (registered).
- writeRegisterData  output  DATA_WIDTH  to register file (registered).
- shouldWrite  output  1  to register file (registered).
- pendingMask  output  32  bit i = late write to xi outstanding.
- fifoCount  output  $clog2(LATE_FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: shouldWrite=0, writeRegisterIndex=0, writeRegisterData=0, pendingMask=0, FIFO emptied (fifoCount=0). Any in-flight entries are discarded.
- Write outputs are registered. A source selected in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
- Selection per cycle, in strict priority order:
  - (1) ALU if aluWriteValid.
  - (2) else FIFO head if FIFO non-empty.
  - (3) else the incoming late result directly, if lateResultValid (bypass, 1-cycle latency).
  - (4) else shouldWrite=0 next cycle. Index and data hold their last values.
- A late result that is accepted but not selected is pushed to the FIFO tail.
- The FIFO is strictly in-order; no reordering among late results.
- lateResultReady = (fifoCount < LATE_FIFO_DEPTH). It depends only on registered state, so there is no combinational path from the valid inputs.
- Full FIFO with a pop this cycle: ready is still 0 (conservative). Push and pop in the same cycle leave the count unchanged.
- Index 0: the entry is consumed or selected normally, but the emitted shouldWrite=0. pendingMask bit 0 is hardwired 0.
- Scoreboard set: lateIssueValid sets pendingMask[lateIssueIndex] at the next edge.
- Scoreboard clear: bit i clears at the edge where a late entry for xi is selected, i.e. the same edge that raises shouldWrite. ALU writes never clear bits.
- Set and clear of the same index in the same cycle: set wins (a newer op is outstanding).
- ALU and late results targeting the same index in the same cycle: the ALU write is emitted first, the late write follows. Preventing this WAW case is the issue logic's responsibility, not checked here.
- ALU continuously valid: the FIFO may fill and backpressure the late source; no starvation guarantee is required.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds inputs source1RegisterIndex and source2RegisterIndex (5 each), plus outputs bypass1Valid, bypass1Data, bypass2Valid, bypass2Data.
  - bypassNValid = shouldWrite && writeRegisterIndex==sourceNRegisterIndex && index!=0.
  - bypassNData = writeRegisterData.
  - Both are combinational from the registered write stage.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_pkg: REG_INDEX_WIDTH=5, REG_COUNT=32, DATA_WIDTH default, typedef wb_entry_t {index, data}.
- Sub-module wb_result_fifo: synchronous FIFO of wb_entry_t, depth LATE_FIFO_DEPTH, with push/pop/count/full/empty and the same clk/reset.

Test Plan:
- Reset mid-stream: FIFO holding 2 entries and pendingMask=0x00000030, reset=0 for one cycle -> shouldWrite=0, pendingMask=0, fifoCount=0, lateResultReady=1 next cycle.
- Lone ALU write: aluWriteValid with x5=0xDEADBEEF -> next cycle shouldWrite=1, index=5, data=0xDEADBEEF; pendingMask unchanged.
- Bypass path: lateIssue x7, then 3 cycles later a late result x7=0x1234 with FIFO empty and no ALU -> write x7=0x1234 next cycle; pendingMask[7] goes 1 then 0 at that same edge.
- Collision and ordering:
  - Stimulus: ALU x3=1 and late x4=2 in the same cycle, followed by ALU x6=3 with late x8=4.
  - Required response: writes in order x3, x6, x4, x8.
  - Check: fifoCount peaks at 2 and lateResultReady drops to 0 when full.
- x0 handling: late result to x0 -> entry consumed, shouldWrite stays 0, pendingMask bit 0 never set.
- Same-index set and clear: lateIssue x9 coincides with selection of an older x9 result -> pendingMask[9] remains 1.
